// File: rtl/eth_phy_10g_pkg.sv
// Constants shared by the 10G PHY transmit gearbox, encoder and receive block-lock aligner.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA       = 2'b10;
  localparam logic [1:0] SYNC_CTRL       = 2'b01;
  localparam logic [7:0] IDLE_BLOCK_TYPE = 8'h1E;
  localparam logic [5:0] GEARBOX_SEQ_MAX = 6'd32;

endpackage

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66b-to-64b transmit gearbox: packs 32 blocks into 33 SerDes words, substituting
// an idle control block whenever the source has nothing to offer.
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_serdes_tx_data,
  output logic                  o_underflow,
  output logic [5:0]            o_seq
);

  localparam int unsigned BlkW  = HDR_WIDTH + DATA_WIDTH;
  localparam int unsigned WideW = 2 * DATA_WIDTH;

  logic [5:0]            seq_q, seq_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  uf_q, uf_d;

  logic                  consume;
  logic [BlkW-1:0]       blk;
  logic [WideW-1:0]      packed_w;

  assign consume = (seq_q != GEARBOX_SEQ_MAX);

  assign blk = i_tx_valid ? {i_tx_data, i_tx_hdr}
                          : {DATA_WIDTH'(IDLE_BLOCK_TYPE), SYNC_CTRL};

  // Leftover bits above 2*seq are always zero, so an OR places the new block after them.
  // At most 66+62 = 128 bits are live, so the upper truncated bits are always zero.
  assign packed_w = (WideW'(blk) << {seq_q, 1'b0}) | WideW'(left_q);

  always_comb begin
    seq_d  = seq_q;
    left_d = left_q;
    word_d = word_q;
    uf_d   = 1'b0;
    if (consume) begin
      word_d = packed_w[DATA_WIDTH-1:0];
      left_d = packed_w[DATA_WIDTH +: DATA_WIDTH];
      seq_d  = seq_q + 6'd1;
      uf_d   = ~i_tx_valid;
    end else begin
      // Stall: the leftover holds exactly one full word, flush it.
      word_d = left_q;
      left_d = '0;
      seq_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      left_q <= '0;
      word_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      left_q <= left_d;
      word_q <= word_d;
      uf_q   <= uf_d;
    end
  end

  assign o_tx_ready       = consume;
  assign o_serdes_tx_data = word_q;
  assign o_underflow      = uf_q;
  assign o_seq            = seq_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Directed plus random bench: accepted blocks go into a scoreboard queue and the
// output bitstream is unpacked LSB-first into 66-bit blocks and compared in order.
module tb_eth_phy_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_tx_hdr;
  logic [63:0] i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [63:0] o_serdes_tx_data;
  logic        o_underflow;
  logic [5:0]  o_seq;

  eth_phy_10g_tx_gearbox dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_tx_hdr         (i_tx_hdr),
    .i_tx_data        (i_tx_data),
    .i_tx_valid       (i_tx_valid),
    .o_tx_ready       (o_tx_ready),
    .o_serdes_tx_data (o_serdes_tx_data),
    .o_underflow      (o_underflow),
    .o_seq            (o_seq)
  );

  always #5 clk = ~clk;

  localparam logic [65:0] IdleBlk = {64'h0000_0000_0000_001E, 2'b01};

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [65:0] exp_q[$];
  bit          sbits[$];
  int unsigned mseq;
  int unsigned cyc;
  int unsigned consumed;
  int unsigned uf_count;
  int unsigned stall_count;
  int unsigned stall_cyc[$];
  logic [63:0] last_word;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [65:0] got;
    logic [65:0] want;
    while (sbits.size() >= 66) begin
      for (int i = 0; i < 66; i++) got[i] = sbits.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty observed=%0h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        check("sb_block", got, want);
      end
    end
  endtask

  // One clock cycle: drive inputs, update the model, then sample #1 after the edge.
  task automatic cycle(input logic v, input logic [1:0] hdr, input logic [63:0] data);
    logic exp_uf;
    logic rdy;
    rdy = (mseq != 32);
    check("ready", 66'(o_tx_ready), 66'(rdy));
    if (!rdy) begin
      stall_count++;
      stall_cyc.push_back(cyc);
    end
    i_tx_valid = v;
    i_tx_hdr   = hdr;
    i_tx_data  = data;
    if (rdy) begin
      exp_q.push_back(v ? {data, hdr} : IdleBlk);
      exp_uf = ~v;
      if (v) consumed++;
      else uf_count++;
      mseq++;
    end else begin
      exp_uf = 1'b0;
      mseq   = 0;
    end
    @(posedge clk);
    #1;
    check("seq", 66'(o_seq), 66'(mseq));
    check("underflow", 66'(o_underflow), 66'(exp_uf));
    last_word = o_serdes_tx_data;
    for (int i = 0; i < 64; i++) sbits.push_back(o_serdes_tx_data[i]);
    drain();
    cyc++;
  endtask

  task automatic rand_cycle(input logic v);
    cycle(v, 2'($urandom_range(1, 2)), {$urandom, $urandom});
  endtask

  task automatic model_reset();
    mseq = 0;
    cyc = 0;
    consumed = 0;
    uf_count = 0;
    stall_count = 0;
    stall_cyc.delete();
    exp_q.delete();
    sbits.delete();
  endtask

  initial begin
    int unsigned guard;
    rst_n      = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_hdr   = 2'b00;
    i_tx_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 66'(o_serdes_tx_data), 66'd0);
    check("rst_uf", 66'(o_underflow), 66'd0);
    check("rst_seq", 66'(o_seq), 66'd0);
    check("rst_ready", 66'(o_tx_ready), 66'd1);
    rst_n = 1'b1;

    // First block after reset starts at bit 0.
    cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    check("first_word", 66'(last_word), 66'hFFFF_FFFF_FFFF_FFFE);
    check("first_seq", 66'(o_seq), 66'd1);

    // Continuous valid for 66 cycles total.
    for (int i = 1; i < 66; i++) rand_cycle(1'b1);
    check("stall_count", 66'(stall_count), 66'd2);
    check("stall_0", 66'(stall_cyc[0]), 66'd32);
    check("stall_1", 66'(stall_cyc[1]), 66'd65);
    check("consumed_64", 66'(consumed), 66'd64);
    check("no_underflow", 66'(uf_count), 66'd0);

    // Underflow at seq 5.
    while (mseq != 5) rand_cycle(1'b1);
    cycle(1'b0, 2'b10, 64'h1234_5678_9ABC_DEF0);
    check("uf_pulse", 66'(o_underflow), 66'd1);
    check("uf_seq", 66'(o_seq), 66'd6);
    rand_cycle(1'b1);
    check("uf_clear", 66'(o_underflow), 66'd0);

    // Block held valid across the stall is consumed exactly once.
    while (mseq != 32) rand_cycle(1'b1);
    cycle(1'b1, 2'b10, 64'hA5A5_5A5A_DEAD_BEEF);
    check("held_not_taken", 66'(o_seq), 66'd0);
    cycle(1'b1, 2'b10, 64'hA5A5_5A5A_DEAD_BEEF);
    check("held_taken", 66'(o_seq), 66'd1);
    for (int i = 0; i < 40; i++) rand_cycle(1'b1);

    // Asynchronous reset at seq 17.
    while (mseq != 17) rand_cycle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 66'(o_serdes_tx_data), 66'd0);
    check("arst_uf", 66'(o_underflow), 66'd0);
    check("arst_seq", 66'(o_seq), 66'd0);
    check("arst_ready", 66'(o_tx_ready), 66'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_realign", 66'(last_word), 66'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 1; i < 34; i++) rand_cycle(1'b1);
    check("reset_period", 66'(stall_cyc[0]), 66'd32);

    // Random blocks with random gaps.
    for (int i = 0; i < 10000; i++) rand_cycle($urandom_range(0, 3) != 0);

    // Flush to a period boundary so every block has left the gearbox.
    guard = 0;
    rand_cycle(1'b1);
    while (mseq != 0 && guard < 40) begin
      rand_cycle(1'b1);
      guard++;
    end
    check("flush_seq", 66'(mseq), 66'd0);
    check("sb_left", 66'(exp_q.size()), 66'd0);
    check("bits_left", 66'(sbits.size()), 66'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
